// File: rtl/neuron_update_sequencer_pkg.sv
// Shared fixed-point widths and sequencer state encoding.
// Used by the sequencer, its counter bank and the external leak datapath.
package neuron_update_sequencer_pkg;

  localparam int NUS_INTEGER_WIDTH = 16;
  localparam int NUS_DATA_WIDTH_FRAC = 32;
  localparam int NUS_NEURON_ADDR_WIDTH = 8;
  localparam int NUS_REFRACTORY_WIDTH = 4;

  localparam int NUS_STATE_W = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

endpackage

// File: rtl/neuron_update_sequencer_refractory_counter_bank.sv
// One refractory counter per neuron; read, decrement or load at idx_i.
// Ports: clk/rst_n, idx_i, dec_i, load_i (wins), load_val_i, count_o.
module refractory_counter_bank
  import neuron_update_sequencer_pkg::*;
#(
  parameter int AW = NUS_NEURON_ADDR_WIDTH,
  parameter int RW = NUS_REFRACTORY_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] idx_i,
  input  logic          dec_i,
  input  logic          load_i,
  input  logic [RW-1:0] load_val_i,
  output logic [RW-1:0] count_o
);

  localparam int DEPTH = 2 ** AW;

  logic [RW-1:0] cnt_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (load_i) begin
      cnt_q[idx_i] <= load_val_i;
    end else if (dec_i) begin
      cnt_q[idx_i] <= cnt_q[idx_i] - RW'(1);
    end
  end

  assign count_o = cnt_q[idx_i];

endmodule

// File: rtl/neuron_update_sequencer.sv
// Sweeps NeuronCount neurons: read Vmem, leak externally, spike/write back.
// Ports: Clock/Reset, Start+params, Vmem RAM rd/wr, leak loop, Spike, Busy/Done.
module neuron_update_sequencer
  import neuron_update_sequencer_pkg::*;
#(
  parameter int INTEGER_WIDTH     = NUS_INTEGER_WIDTH,
  parameter int DATA_WIDTH_FRAC   = NUS_DATA_WIDTH_FRAC,
  parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int NEURON_ADDR_WIDTH = NUS_NEURON_ADDR_WIDTH,
  parameter int REFRACTORY_WIDTH  = NUS_REFRACTORY_WIDTH
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic                                Start,
  input  logic [NEURON_ADDR_WIDTH:0]          NeuronCount,
  input  logic signed [INTEGER_WIDTH-1:0]     Vth,
  input  logic signed [INTEGER_WIDTH-1:0]     Vreset,
  input  logic [REFRACTORY_WIDTH-1:0]         RefPeriod,
  output logic                                VmemRdEn,
  output logic [NEURON_ADDR_WIDTH-1:0]        VmemRdAddr,
  input  logic signed [DATA_WIDTH-1:0]        VmemRdData,
  output logic signed [DATA_WIDTH-1:0]        LeakVmemIn,
  input  logic signed [DATA_WIDTH-1:0]        LeakVmemOut,
  output logic                                VmemWrEn,
  output logic [NEURON_ADDR_WIDTH-1:0]        VmemWrAddr,
  output logic signed [DATA_WIDTH-1:0]        VmemWrData,
  output logic                                SpikeValid,
  output logic [NEURON_ADDR_WIDTH-1:0]        SpikeAddr,
  output logic                                Busy,
  output logic                                Done
);

  localparam int AW = NEURON_ADDR_WIDTH;
  localparam int IW = INTEGER_WIDTH;
  localparam int FW = DATA_WIDTH_FRAC;
  localparam int DW = DATA_WIDTH;
  localparam int RW = REFRACTORY_WIDTH;

  logic [NUS_STATE_W-1:0] state_q, state_d;
  logic [AW:0]            idx_q, cnt_q;
  logic signed [IW-1:0]   vth_q, vrst_q;
  logic [RW-1:0]          ref_q;
  logic signed [DW-1:0]   vmem_q;

  logic                   is_read, is_latch;
  logic                   is_upd, is_fin;
  logic [AW:0]            idx_inc;
  logic                   last;
  logic [RW-1:0]          refr;
  logic                   refr_act, fire;
  logic signed [DW-1:0]   vth_pad, vrst_pad;
  logic [AW-1:0]          addr;

  assign is_read  = (state_q == ST_READ);
  assign is_latch = (state_q == ST_LATCH);
  assign is_upd   = (state_q == ST_UPDATE);
  assign is_fin   = (state_q == ST_FINISH);

  // idx_q is one bit wider so a full 2^AW sweep ends without wrapping.
  assign idx_inc = idx_q + (AW+1)'(1);
  assign last    = (idx_inc >= cnt_q);
  assign addr    = idx_q[AW-1:0];

  assign vth_pad  = {vth_q, {FW{1'b0}}};
  assign vrst_pad = {vrst_q, {FW{1'b0}}};

  assign refr_act = |refr;
  assign fire     = is_upd & ~refr_act &
                    (LeakVmemOut >= vth_pad);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (Start) begin
          state_d = (NeuronCount == '0) ?
                    ST_FINISH : ST_READ;
        end
      ST_READ:   state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_UPDATE;
      ST_UPDATE: state_d = last ? ST_FINISH : ST_READ;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vth_q   <= '0;
      vrst_q  <= '0;
      ref_q   <= '0;
      vmem_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && Start) begin
        cnt_q  <= NeuronCount;
        vth_q  <= Vth;
        vrst_q <= Vreset;
        ref_q  <= RefPeriod;
        idx_q  <= '0;
      end
      if (is_latch) begin
        vmem_q <= VmemRdData;
      end
      if (is_upd) begin
        idx_q <= idx_inc;
      end
    end
  end

  refractory_counter_bank #(
    .AW (AW),
    .RW (RW)
  ) u_refr (
    .clk        (Clock),
    .rst_n      (Reset),
    .idx_i      (addr),
    .dec_i      (is_upd & refr_act),
    .load_i     (fire),
    .load_val_i (ref_q),
    .count_o    (refr)
  );

  assign VmemRdEn   = is_read;
  assign VmemRdAddr = is_read ? addr : '0;
  assign LeakVmemIn = vmem_q;

  assign VmemWrEn   = is_upd;
  assign VmemWrAddr = is_upd ? addr : '0;
  always_comb begin
    VmemWrData = '0;
    if (is_upd) begin
      VmemWrData = (refr_act | fire) ?
                   vrst_pad : LeakVmemOut;
    end
  end

  assign SpikeValid = fire;
  assign SpikeAddr  = fire ? addr : '0;
  assign Busy       = is_read | is_latch | is_upd;
  assign Done       = is_fin;

endmodule

// File: tb/tb_neuron_update_sequencer.sv
// Randomized scoreboard bench for neuron_update_sequencer.
// Reference model works per neuron from the sweep rules on plain arrays.
module tb_neuron_update_sequencer;

  localparam int IW = 16;
  localparam int FW = 32;
  localparam int DW = 48;
  localparam int AW = 8;
  localparam int RW = 4;
  localparam int NN = 256;

  logic                 Clock = 1'b0;
  logic                 Reset = 1'b0;
  logic                 Start = 1'b0;
  logic [AW:0]          NeuronCount = '0;
  logic signed [IW-1:0] Vth = '0;
  logic signed [IW-1:0] Vreset = '0;
  logic [RW-1:0]        RefPeriod = '0;
  logic                 VmemRdEn;
  logic [AW-1:0]        VmemRdAddr;
  logic signed [DW-1:0] VmemRdData;
  logic signed [DW-1:0] LeakVmemIn;
  logic signed [DW-1:0] LeakVmemOut;
  logic                 VmemWrEn;
  logic [AW-1:0]        VmemWrAddr;
  logic signed [DW-1:0] VmemWrData;
  logic                 SpikeValid;
  logic [AW-1:0]        SpikeAddr;
  logic                 Busy;
  logic                 Done;

  neuron_update_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .NeuronCount (NeuronCount),
    .Vth         (Vth),
    .Vreset      (Vreset),
    .RefPeriod   (RefPeriod),
    .VmemRdEn    (VmemRdEn),
    .VmemRdAddr  (VmemRdAddr),
    .VmemRdData  (VmemRdData),
    .LeakVmemIn  (LeakVmemIn),
    .LeakVmemOut (LeakVmemOut),
    .VmemWrEn    (VmemWrEn),
    .VmemWrAddr  (VmemWrAddr),
    .VmemWrData  (VmemWrData),
    .SpikeValid  (SpikeValid),
    .SpikeAddr   (SpikeAddr),
    .Busy        (Busy),
    .Done        (Done)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // leak datapath stand-in: subtract a constant
  logic signed [DW-1:0] leak_delta = '0;
  assign LeakVmemOut = LeakVmemIn - leak_delta;

  // state RAM: one-cycle read latency; images loaded via token handshake
  logic signed [DW-1:0] ram [NN];
  logic signed [DW-1:0] img [NN];
  logic signed [DW-1:0] rdata = '0;
  int load_tok = 0;
  int load_seen = 0;
  assign VmemRdData = rdata;

  always @(posedge Clock) begin
    if (load_tok != load_seen) begin
      for (int i = 0; i < NN; i++) ram[i] <= img[i];
      load_seen <= load_tok;
    end else if (VmemWrEn) begin
      ram[VmemWrAddr] <= VmemWrData;
    end
    if (VmemRdEn) rdata <= ram[VmemRdAddr];
  end

  typedef struct {
    int                   cyc;
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] data;
    bit                   spike;
    logic signed [DW-1:0] pre;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  checks = 0;
  int  passes = 0;
  int  c0 = -1000;
  int  n0 = 0;

  logic signed [DW-1:0] exp_mem [NN];
  int                   exp_refr [NN];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  nm, act, exp, cyc);
  endtask

  function automatic logic signed [DW-1:0] pad(
      input logic signed [IW-1:0] x);
    return {x, {FW{1'b0}}};
  endfunction

  // monitor: pops the scoreboard whenever the DUT writes or finishes
  always @(negedge Clock) begin
    wr_t e;
    int d;
    int rel;
    bit exp_rd;
    if (Reset) begin
      rel = cyc - c0;
      exp_rd = (rel >= 1) && (rel <= 3 * n0) &&
               ((rel - 1) % 3 == 0);
      chk("rd_en", VmemRdEn, exp_rd);
      if (exp_rd) chk("rd_addr", VmemRdAddr, (rel - 1) / 3);
      chk("busy", Busy, (rel >= 1) && (rel <= 3 * n0));
      if (VmemWrEn) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", VmemWrAddr, e.addr);
          chk("leak_in", LeakVmemIn, e.pre);
          chk("wr_data", VmemWrData, e.data);
          chk("spike", SpikeValid, e.spike);
          if (e.spike) chk("spike_addr", SpikeAddr, e.addr);
        end
      end else if (SpikeValid) begin
        chk("spike_without_write", 1, 0);
      end
      if (Done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", cyc, d);
        end
      end
    end
  end

  task automatic load_img();
    for (int k = 0; k < NN; k++) exp_mem[k] = img[k];
    load_tok++;
    @(posedge Clock);
    #1;
  endtask

  task automatic sweep(input int n,
                       input logic signed [IW-1:0] vth,
                       input logic signed [IW-1:0] vrst,
                       input logic [RW-1:0] rp,
                       input bit perturb, input bit dbl);
    int c;
    logic signed [DW-1:0] pre, v, d;
    bit sp;
    c = cyc;
    for (int k = 0; k < n; k++) begin
      pre = exp_mem[k];
      v = pre - leak_delta;
      sp = 1'b0;
      if (exp_refr[k] > 0) begin
        d = pad(vrst);
        exp_refr[k]--;
      end else if (v >= pad(vth)) begin
        d = pad(vrst);
        sp = 1'b1;
        exp_refr[k] = int'(rp);
      end else begin
        d = v;
      end
      exp_mem[k] = d;
      wq.push_back('{c + 3 * k + 3, k[AW-1:0], d, sp, pre});
    end
    dq.push_back(c + 3 * n + 1);
    c0 = c;
    n0 = n;
    NeuronCount = (AW+1)'(n);
    Vth = vth;
    Vreset = vrst;
    RefPeriod = rp;
    Start = 1'b1;
    for (int i = 0; i < 3 * n + 3; i++) begin
      @(posedge Clock);
      #1;
      Start = (dbl && i == 1);
      if (perturb) begin
        NeuronCount = (AW+1)'($urandom_range(0, NN));
        Vth = IW'($urandom);
        Vreset = IW'($urandom);
        RefPeriod = RW'($urandom);
      end
    end
    Start = 1'b0;
    chk("scoreboard_drained", wq.size() + dq.size(), 0);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_rd_en"}, VmemRdEn, 0);
    chk({tag, "_rd_addr"}, VmemRdAddr, 0);
    chk({tag, "_leak_in"}, LeakVmemIn, 0);
    chk({tag, "_wr_en"}, VmemWrEn, 0);
    chk({tag, "_wr_addr"}, VmemWrAddr, 0);
    chk({tag, "_wr_data"}, VmemWrData, 0);
    chk({tag, "_spike"}, SpikeValid, 0);
    chk({tag, "_spike_addr"}, SpikeAddr, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
  endtask

  task automatic fill_img(input logic signed [IW-1:0] v);
    for (int k = 0; k < NN; k++) img[k] = pad(v);
  endtask

  initial begin
    int n, c;
    logic signed [IW-1:0] vth, vrst;
    for (int k = 0; k < NN; k++) exp_refr[k] = 0;
    fill_img(-16'sd65);
    load_img();
    repeat (2) @(posedge Clock);
    #1;
    zero_check("reset");
    @(posedge Clock);
    #1;
    Reset = 1'b1;

    // reference sweep, then refractory reruns
    img[0] = pad(-16'sd65);
    img[1] = pad(-16'sd60);
    img[2] = pad(-16'sd50);
    for (int k = 0; k < NN; k++) exp_mem[k] = img[k];
    load_tok++;
    sweep(3, -16'sd55, -16'sd70, 4'd2, 1'b0, 1'b0);
    sweep(3, -16'sd55, -16'sd70, 4'd2, 1'b1, 1'b0);
    sweep(3, -16'sd55, -16'sd70, 4'd2, 1'b0, 1'b0);
    img[2] = pad(-16'sd50);
    load_img();
    sweep(3, -16'sd55, -16'sd70, 4'd2, 1'b0, 1'b0);

    // threshold boundary, zero refractory period
    fill_img(-16'sd80);
    img[3] = pad(-16'sd55);
    img[4] = pad(-16'sd55) - 48'sd1;
    img[5] = pad(-16'sd55) + 48'sd5;
    load_img();
    leak_delta = 48'sd5;
    sweep(6, -16'sd55, -16'sd70, 4'd0, 1'b0, 1'b0);
    leak_delta = '0;
    load_img();
    sweep(6, -16'sd55, -16'sd70, 4'd0, 1'b0, 1'b0);

    // empty sweep, Start while busy
    sweep(0, -16'sd55, -16'sd70, 4'd1, 1'b0, 1'b0);
    sweep(4, -16'sd55, -16'sd70, 4'd1, 1'b0, 1'b1);

    // randomized sweeps
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 24);
      vth = -16'sd50 + IW'($urandom_range(0, 20));
      vrst = -16'sd80 + IW'($urandom_range(0, 20));
      if ($urandom_range(0, 2) != 0) begin
        for (int k = 0; k < NN; k++) begin
          img[k] = pad(vth + IW'($urandom_range(0, 4)) - 16'sd2)
                   + DW'($urandom_range(0, 2)) - DW'(1);
        end
        load_img();
      end
      leak_delta = DW'($urandom_range(0, 2));
      sweep(n, vth, vrst, RW'($urandom_range(0, 3)),
            1'b1, $urandom_range(0, 1) == 1);
    end
    leak_delta = '0;

    // reset during UPDATE of neuron 1
    fill_img(-16'sd100);
    img[0] = pad(16'sd100);
    load_img();
    sweep(3, 16'sd0, -16'sd70, 4'd3, 1'b0, 1'b0);
    fill_img(-16'sd100);
    img[0] = pad(16'sd100);
    img[1] = pad(16'sd7);
    load_img();
    c = cyc;
    wq.push_back('{c + 3, 8'd0, pad(-16'sd70), 1'b0, img[0]});
    exp_mem[0] = pad(-16'sd70);
    c0 = c;
    n0 = 3;
    NeuronCount = 9'd3;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    chk("pre_reset_wr_en", VmemWrEn, 1);
    chk("pre_reset_wr_addr", VmemWrAddr, 1);
    Reset = 1'b0;
    #1;
    zero_check("async_reset");
    wq.delete();
    dq.delete();
    c0 = -1000;
    n0 = 0;
    for (int k = 0; k < NN; k++) exp_refr[k] = 0;
    @(posedge Clock);
    #1;
    chk("no_partial_write", ram[1], img[1]);
    Reset = 1'b1;
    fill_img(-16'sd100);
    img[0] = pad(16'sd100);
    load_img();
    sweep(2, 16'sd0, -16'sd70, 4'd3, 1'b0, 1'b0);

    // full address range
    for (int k = 0; k < NN; k++) begin
      img[k] = pad(IW'($urandom_range(0, 20)) - 16'sd10);
    end
    load_img();
    sweep(NN, 16'sd0, -16'sd5, 4'd1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1, "timeout");
  end

endmodule
